multichan_pwm_audio: RTL and testbench

Wishbone-controlled multi-channel audio output: NCHAN signed sample streams drive NCHAN one-bit outputs.
- Successor to the single-sample PWM audio controller; adds a sample-frame FIFO, a run-time programmable sample rate, and a selectable output mode (traditional PWM or first-order sigma-delta PDM).
- Underrun/overflow detection and a fill-threshold interrupt.
- Sits on the peripheral Wishbone bus; outputs feed external RC filters/amplifiers.

---
 rtl/pwm_audio_pkg.sv | 19 +
 rtl/sync_fifo.sv | 49 ++++
 rtl/multichan_pwm_audio.sv | 220 ++++++++++++++++++++++
 tb/tb_multichan_pwm_audio.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_audio_pkg.sv
// Register map, field positions and output-mode encodings for multichan_pwm_audio.
package pwm_audio_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_CTRL   = 2'd1;
    localparam logic [1:0] ADDR_STAT   = 2'd2;
    localparam logic [1:0] ADDR_THRESH = 2'd3;

    localparam int CTRL_MODE_BIT     = 24;
    localparam int STAT_UNDERRUN_BIT = 31;
    localparam int STAT_OVERFLOW_BIT = 30;
    localparam int STAT_IE_BIT       = 29;

    typedef enum logic {
        MODE_PWM = 1'b0,
        MODE_PDM = 1'b1
    } mode_e;

endpackage

// File: rtl/sync_fifo.sv
// Frame FIFO: single clock, push on full and pop on empty are ignored.
module sync_fifo #(
    parameter int WIDTH  = 32,
    parameter int LGFIFO = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_push,
    input  logic [WIDTH-1:0]  i_data,
    input  logic              i_pop,
    output logic [WIDTH-1:0]  o_data,
    output logic              o_full,
    output logic              o_empty,
    output logic [LGFIFO:0]   o_fill
);

    localparam int DEPTH = 1 << LGFIFO;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [LGFIFO:0]  r_wptr;
    logic [LGFIFO:0]  r_rptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_fill    = r_wptr - r_rptr;
    assign o_full    = o_fill[LGFIFO];
    assign o_empty   = (o_fill == '0);
    assign o_data    = r_mem[r_rptr[LGFIFO-1:0]];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Pointer update; emptiness is judged on the pre-edge state, so a push
    // into an empty FIFO cannot be popped in the same cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + (LGFIFO+1)'(1);
            if (w_do_pop)  r_rptr <= r_rptr + (LGFIFO+1)'(1);
        end
    end

    // Storage write
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wptr[LGFIFO-1:0]] <= i_data;
    end

endmodule

// File: rtl/multichan_pwm_audio.sv
// Wishbone multi-channel audio output: frame FIFO, programmable sample rate,
// PWM or first-order sigma-delta PDM per channel.
module multichan_pwm_audio
    import pwm_audio_pkg::*;
#(
    parameter int NCHAN          = 2,
    parameter int SAMPLE_BITS    = 16,
    parameter int LGFIFO         = 4,
    parameter int TIMING_BITS    = 16,
    parameter int DEFAULT_RELOAD = 1814,
    parameter int NAUX           = 2
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_wb_cyc,
    input  logic              i_wb_stb,
    input  logic              i_wb_we,
    input  logic [1:0]        i_wb_addr,
    input  logic [31:0]       i_wb_data,
    output logic              o_wb_ack,
    output logic              o_wb_stall,
    output logic [31:0]       o_wb_data,
    output logic [NCHAN-1:0]  o_pwm,
    output logic [NAUX-1:0]   o_aux,
    output logic              o_int
);

    localparam int FW = NCHAN * SAMPLE_BITS;
    localparam logic [TIMING_BITS-1:0] RESET_RELOAD = TIMING_BITS'(DEFAULT_RELOAD);

    logic [TIMING_BITS-1:0] r_reload;
    mode_e                  r_mode;
    logic [NAUX-1:0]        r_aux;
    logic                   r_ie;
    logic [LGFIFO:0]        r_thresh;
    logic                   r_underrun;
    logic                   r_overflow;
    logic [TIMING_BITS-1:0] r_timer;
    logic [TIMING_BITS-1:0] r_cnt;
    logic [FW-1:0]          r_frame;
    logic [TIMING_BITS:0]   r_acc [NCHAN];
    logic [NCHAN-1:0]       r_pwm;
    logic                   r_int;
    logic                   r_ack;
    logic [31:0]            r_rdata;

    logic                   w_wr, w_wr_data, w_wr_ctrl, w_wr_stat, w_wr_thresh;
    logic                   w_tick, w_mode_change;
    logic                   w_fifo_full, w_fifo_empty;
    logic [LGFIFO:0]        w_fill;
    logic [FW-1:0]          w_head;
    logic signed [TIMING_BITS+1:0] w_level [NCHAN];
    logic [TIMING_BITS-1:0] w_duty [NCHAN];
    logic [TIMING_BITS:0]   w_pdm_sum [NCHAN];
    logic [NCHAN-1:0]       w_pdm_hit;
    logic [31:0]            w_ctrl_rd, w_stat_rd;

    assign w_wr          = i_wb_cyc && i_wb_stb && i_wb_we;
    assign w_wr_data     = w_wr && (i_wb_addr == ADDR_DATA);
    assign w_wr_ctrl     = w_wr && (i_wb_addr == ADDR_CTRL);
    assign w_wr_stat     = w_wr && (i_wb_addr == ADDR_STAT);
    assign w_wr_thresh   = w_wr && (i_wb_addr == ADDR_THRESH);
    assign w_tick        = (r_timer == '0);
    assign w_mode_change = w_wr_ctrl && (mode_e'(i_wb_data[CTRL_MODE_BIT]) != r_mode);

    sync_fifo #(
        .WIDTH  (FW),
        .LGFIFO (LGFIFO)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (w_wr_data),
        .i_data  (i_wb_data[FW-1:0]),
        .i_pop   (w_tick),
        .o_data  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_fill  (w_fill)
    );

    // Sample-to-duty conversion (offset by half period, clamped) and PDM step
    always_comb begin
        w_pdm_hit = '0;
        for (int unsigned k = 0; k < NCHAN; k++) begin
            w_level[k]   = '0;
            w_duty[k]    = '0;
            w_pdm_sum[k] = '0;
        end
        for (int unsigned k = 0; k < NCHAN; k++) begin
            w_level[k] = (TIMING_BITS+2)'($signed(r_frame[k*SAMPLE_BITS +: SAMPLE_BITS]))
                       + $signed({2'b00, r_reload >> 1});
            if (w_level[k][TIMING_BITS+1])
                w_duty[k] = '0;
            else if (w_level[k] > $signed({2'b00, r_reload}))
                w_duty[k] = r_reload;
            else
                w_duty[k] = w_level[k][TIMING_BITS-1:0];
            w_pdm_sum[k] = r_acc[k] + {1'b0, w_duty[k]};
            w_pdm_hit[k] = (w_pdm_sum[k] >= {1'b0, r_reload});
        end
    end

    // Control/status registers and sticky error flags (a set beats a same-cycle clear)
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_reload   <= RESET_RELOAD;
            r_mode     <= MODE_PWM;
            r_aux      <= '0;
            r_ie       <= 1'b0;
            r_thresh   <= '0;
            r_underrun <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_reload <= i_wb_data[TIMING_BITS-1:0];
                r_mode   <= mode_e'(i_wb_data[CTRL_MODE_BIT]);
                r_aux    <= i_wb_data[31 -: NAUX];
            end
            if (w_wr_stat) begin
                r_ie <= i_wb_data[STAT_IE_BIT];
                if (i_wb_data[STAT_UNDERRUN_BIT]) r_underrun <= 1'b0;
                if (i_wb_data[STAT_OVERFLOW_BIT]) r_overflow <= 1'b0;
            end
            if (w_wr_thresh) r_thresh <= i_wb_data[LGFIFO:0];
            if (w_tick && w_fifo_empty) r_underrun <= 1'b1;
            if (w_wr_data && w_fifo_full) r_overflow <= 1'b1;
        end
    end

    // Sample-period timer and PWM phase counter, both realigned by a CTRL write
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_timer <= RESET_RELOAD - TIMING_BITS'(1);
            r_cnt   <= '0;
        end else if (w_wr_ctrl) begin
            r_timer <= i_wb_data[TIMING_BITS-1:0] - TIMING_BITS'(1);
            r_cnt   <= '0;
        end else if (w_tick) begin
            r_timer <= r_reload - TIMING_BITS'(1);
            r_cnt   <= '0;
        end else begin
            r_timer <= r_timer - TIMING_BITS'(1);
            r_cnt   <= r_cnt + TIMING_BITS'(1);
        end
    end

    // Output frame: next FIFO frame on tick, otherwise hold
    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_frame <= '0;
        else if (w_tick && !w_fifo_empty)
            r_frame <= w_head;
    end

    // Per-channel bit generation in the selected mode
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pwm <= '0;
            for (int unsigned k = 0; k < NCHAN; k++) r_acc[k] <= '0;
        end else begin
            for (int unsigned k = 0; k < NCHAN; k++) begin
                if (r_mode == MODE_PDM)
                    r_pwm[k] <= w_pdm_hit[k];
                else
                    r_pwm[k] <= (r_cnt < w_duty[k]);
                if (w_mode_change)
                    r_acc[k] <= '0;
                else if (r_mode == MODE_PDM)
                    r_acc[k] <= w_pdm_hit[k] ? (w_pdm_sum[k] - {1'b0, r_reload}) : w_pdm_sum[k];
            end
        end
    end

    // Fill-threshold interrupt
    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_int <= 1'b0;
        else
            r_int <= r_ie && (w_fill <= r_thresh);
    end

    // Read-back images of CTRL and STAT
    always_comb begin
        w_ctrl_rd                    = '0;
        w_ctrl_rd[TIMING_BITS-1:0]   = r_reload;
        w_ctrl_rd[CTRL_MODE_BIT]     = r_mode;
        w_ctrl_rd[31 -: NAUX]        = r_aux;
        w_stat_rd                    = '0;
        w_stat_rd[STAT_UNDERRUN_BIT] = r_underrun;
        w_stat_rd[STAT_OVERFLOW_BIT] = r_overflow;
        w_stat_rd[STAT_IE_BIT]       = r_ie;
        w_stat_rd[LGFIFO:0]          = w_fill;
    end

    // Bus acknowledge and registered read data
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ack   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ack <= i_wb_stb;
            if (i_wb_stb) begin
                case (i_wb_addr)
                    ADDR_DATA:   r_rdata <= 32'(r_frame);
                    ADDR_CTRL:   r_rdata <= w_ctrl_rd;
                    ADDR_STAT:   r_rdata <= w_stat_rd;
                    default:     r_rdata <= 32'(r_thresh);
                endcase
            end
        end
    end

    assign o_wb_ack   = r_ack;
    assign o_wb_stall = 1'b0;
    assign o_wb_data  = r_rdata;
    assign o_pwm      = r_pwm;
    assign o_aux      = r_aux;
    assign o_int      = r_int;

endmodule

// File: tb/tb_multichan_pwm_audio.sv
// Randomized self-checking bench for multichan_pwm_audio against a
// period-level reference of duty, FIFO fill and interrupt behaviour.
module tb_multichan_pwm_audio;
    import pwm_audio_pkg::*;

    localparam int NCHAN       = 2;
    localparam int SB          = 16;
    localparam int NAUX        = 2;
    localparam int DEF_RELOAD  = 1814;
    localparam int HOLD_RELOAD = 60000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [1:0]        addr = '0;
    logic [31:0]       wdata = '0;
    logic              ack, stall, irq;
    logic [31:0]       rdata;
    logic [NCHAN-1:0]  pwm;
    logic [NAUX-1:0]   aux;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_n   = 0;
    logic [31:0] frames [$];
    logic [31:0] last_mask [NCHAN];

    multichan_pwm_audio #(
        .NCHAN          (NCHAN),
        .SAMPLE_BITS    (SB),
        .LGFIFO         (4),
        .TIMING_BITS    (16),
        .DEFAULT_RELOAD (DEF_RELOAD),
        .NAUX           (NAUX)
    ) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_wb_cyc   (cyc),
        .i_wb_stb   (stb),
        .i_wb_we    (we),
        .i_wb_addr  (addr),
        .i_wb_data  (wdata),
        .o_wb_ack   (ack),
        .o_wb_stall (stall),
        .o_wb_data  (rdata),
        .o_pwm      (pwm),
        .o_aux      (aux),
        .o_int      (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wb_write(input logic [1:0] a, input logic [31:0] d, output int wedge);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        wedge = edge_n;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = a;
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
        d = rdata;
        check("read_ack", 32'(ack), 32'd1);
    endtask

    task automatic wait_edge(input int target);
        while (edge_n < target) @(negedge clk);
    endtask

    function automatic int duty_of(input logic [15:0] s, input int reload);
        int v;
        v = int'($signed(s)) + reload / 2;
        if (v < 0) return 0;
        if (v > reload) return reload;
        return v;
    endfunction

    // Queue `frames` behind a long period, then start the target period and
    // observe one full period per frame.
    task automatic run_frames(input int mode, input int reload, input string name);
        int w;
        int du;
        logic [31:0] d;
        logic [31:0] f;
        logic [31:0] mask [NCHAN];
        logic [NAUX-1:0] aux_v;
        wb_write(ADDR_CTRL, 32'(HOLD_RELOAD), w);
        foreach (frames[i]) wb_write(ADDR_DATA, frames[i], w);
        aux_v = NAUX'($urandom);
        d = 32'(reload) | (32'(mode) << 24) | {aux_v, 30'd0};
        wb_write(ADDR_CTRL, d, w);
        check($sformatf("%s_aux", name), 32'(aux), 32'(aux_v));
        wait_edge(w + reload);
        foreach (frames[i]) begin
            f = frames[i];
            for (int k = 0; k < NCHAN; k++) mask[k] = '0;
            for (int j = 0; j < reload; j++) begin
                @(negedge clk);
                for (int k = 0; k < NCHAN; k++) mask[k][j] = pwm[k];
            end
            for (int k = 0; k < NCHAN; k++) begin
                du = duty_of(f[k*SB +: SB], reload);
                last_mask[k] = mask[k];
                if (mode == 0)
                    check($sformatf("%s_pwm_f%0d_ch%0d", name, i, k), mask[k],
                          (32'(1) << du) - 32'(1));
                else
                    check($sformatf("%s_pdm_f%0d_ch%0d", name, i, k),
                          32'($countones(mask[k])), 32'(du));
            end
        end
        wb_read(ADDR_DATA, d);
        check($sformatf("%s_dataread", name), d, frames[frames.size()-1]);
    endtask

    function automatic int fill_after(input int x, input int w);
        int v;
        if (x < w) return 16;
        v = 16 - (x - w) / 20;
        return (v < 0) ? 0 : v;
    endfunction

    initial begin
        int w;
        int w2;
        int s;
        int mode;
        int reload;
        int nfr;
        logic [31:0] d;
        logic [31:0] f;

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_pwm", 32'(pwm), 32'd0);
        check("rst_int", 32'(irq), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_aux", 32'(aux), 32'd0);
        wb_read(ADDR_STAT, d);   check("rst_stat", d, 32'd0);
        wb_read(ADDR_CTRL, d);   check("rst_ctrl", d, 32'(DEF_RELOAD));
        wb_read(ADDR_THRESH, d); check("rst_thresh", d, 32'd0);
        wb_read(ADDR_DATA, d);   check("rst_data", d, 32'd0);

        // Underrun after the first tick of an 8-clock period, read back-to-back
        wb_write(ADDR_CTRL, 32'd8, w);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = ADDR_STAT;
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            check($sformatf("underrun_t%0d", j), 32'(rdata[31]), 32'(j >= 9));
        end
        cyc = 1'b0; stb = 1'b0;

        // Directed PWM: midscale, clamped high, constant low
        frames.delete();
        frames.push_back(32'h0004_0000);
        frames.push_back(32'hFFFC_0000);
        run_frames(0, 8, "pwm_dir");

        // Directed PDM: duty 6 of 8 repeats 3 of every 4 clocks
        frames.delete();
        frames.push_back(32'h0000_0002);
        run_frames(1, 8, "pdm_dir");
        check("pdm_win0", 32'($countones(last_mask[0][3:0])), 32'd3);
        check("pdm_win1", 32'($countones(last_mask[0][7:4])), 32'd3);

        // Randomized rounds
        for (int r = 0; r < 12; r++) begin
            mode   = int'($urandom_range(0, 1));
            reload = int'($urandom_range(4, 31));
            nfr    = int'($urandom_range(1, 5));
            frames.delete();
            for (int i = 0; i < nfr; i++) begin
                f = '0;
                for (int k = 0; k < NCHAN; k++) begin
                    if ($urandom_range(0, 1) == 1)
                        s = int'($urandom_range(0, reload + 6)) - (reload / 2 + 3);
                    else
                        s = int'($urandom);
                    f[k*SB +: SB] = s[15:0];
                end
                frames.push_back(f);
            end
            run_frames(mode, reload, $sformatf("rnd%0d", r));
        end

        // Overflow: 17 pushes into a 16-deep FIFO, then clear overflow only
        wb_write(ADDR_CTRL, 32'(HOLD_RELOAD), w);
        wb_write(ADDR_STAT, 32'hC000_0000, w);
        for (int i = 0; i < 17; i++) wb_write(ADDR_DATA, 32'h7FFF_7FFF, w);
        wb_read(ADDR_STAT, d); check("ovf_stat", d, 32'h4000_0010);
        wb_write(ADDR_STAT, 32'h6000_0000, w);
        wb_read(ADDR_STAT, d); check("ovf_clear", d, 32'h2000_0010);

        // Threshold interrupt while draining one frame per 20 clocks
        wb_write(ADDR_THRESH, 32'd2, w);
        wb_read(ADDR_THRESH, d); check("thresh_rd", d, 32'd2);
        wb_write(ADDR_CTRL, 32'd20, w);
        for (int i = 0; i < 285; i++) begin
            @(negedge clk);
            check($sformatf("int_e%0d", edge_n - w), 32'(irq),
                  32'(fill_after(edge_n - 1, w) <= 2));
        end
        wb_write(ADDR_CTRL, 32'(HOLD_RELOAD), w2);
        check("int_at_fill2", 32'(irq), 32'd1);
        wb_write(ADDR_DATA, 32'h7FFF_7FFF, w2);
        check("int_latency", 32'(irq), 32'd1);
        @(negedge clk);
        check("int_fall", 32'(irq), 32'd0);

        // Push landing on the tick edge with fill 3
        wb_write(ADDR_CTRL, 32'd8, w);
        wait_edge(w + 6);
        wb_write(ADDR_DATA, 32'h7FFF_7FFF, w2);
        check("tickpush_pwm", 32'(pwm), 32'd3);
        wb_read(ADDR_STAT, d); check("tickpush_stat", d, 32'h2000_0003);

        // Reset mid-stream
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_pwm", 32'(pwm), 32'd0);
        check("mrst_int", 32'(irq), 32'd0);
        check("mrst_aux", 32'(aux), 32'd0);
        wb_read(ADDR_STAT, d);   check("mrst_stat", d, 32'd0);
        wb_read(ADDR_CTRL, d);   check("mrst_ctrl", d, 32'(DEF_RELOAD));
        wb_read(ADDR_DATA, d);   check("mrst_data", d, 32'd0);
        wb_read(ADDR_THRESH, d); check("mrst_thresh", d, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
